// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank write sequencer.
// Control codes, requester indices and FSM state encoding.
package regbank_pkg;

  localparam int NUM_REQ = 6;

  // Requester bit positions; a higher index means a higher priority.
  localparam int REQ_PC   = 0;
  localparam int REQ_CPXR = 1;
  localparam int REQ_ALU  = 2;
  localparam int REQ_MEM  = 3;
  localparam int REQ_RETT = 4;
  localparam int REQ_TRAP = 5;

  localparam logic [2:0] CTRL_PCSP = 3'd0;
  localparam logic [2:0] CTRL_ALU  = 3'd1;
  localparam logic [2:0] CTRL_MEM  = 3'd3;
  localparam logic [2:0] CTRL_TRAP = 3'd4;
  localparam logic [2:0] CTRL_RETT = 3'd5;
  localparam logic [2:0] CTRL_CPXR = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } seq_state_e;

  function automatic logic [2:0] ctrl_code(input logic [NUM_REQ-1:0] grant);
    logic [2:0] code;
    code = CTRL_PCSP;
    if (grant[REQ_TRAP])      code = CTRL_TRAP;
    else if (grant[REQ_RETT]) code = CTRL_RETT;
    else if (grant[REQ_MEM])  code = CTRL_MEM;
    else if (grant[REQ_ALU])  code = CTRL_ALU;
    else if (grant[REQ_CPXR]) code = CTRL_CPXR;
    return code;
  endfunction

endpackage

// File: rtl/regbank_prio_arbiter.sv
// Fixed-priority encoder: the highest-indexed active request wins.
// Purely combinational; the caller registers the grant.
module regbank_prio_arbiter
  import regbank_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) grant = NUM_REQ'(1) << i;
    end
  end

endmodule

// File: rtl/regbank_sequencer.sv
// Sequences register-bank writes from six requesters, one strobe per grant
// followed by a settle cycle, and tracks kernel mode for trap/return.
//
// state     | meaning
// ST_IDLE   | arbitrate; any request launches an operation
// ST_ISSUE  | registered strobe/ack/code/dest presented to the bank
// ST_SETTLE | strobes low, bank read ports refresh; requests ignored
module regbank_sequencer
  import regbank_pkg::*;
#(
  parameter logic [3:0] PC_REGISTER = 4'd15,
  parameter logic [3:0] SP_REGISTER = 4'd14
) (
  input  logic       fast_clock,
  input  logic       reset,
  input  logic       req_trap,
  input  logic       req_rett,
  input  logic       req_mem,
  input  logic       req_alu,
  input  logic       req_cpxr,
  input  logic       req_pc,
  input  logic [3:0] dest_mem,
  input  logic [3:0] dest_alu,
  input  logic [3:0] dest_cpxr,
  output logic [5:0] ack,
  output logic       bank_enable,
  output logic [2:0] bank_control,
  output logic [3:0] bank_dest,
  output logic       privileged,
  output logic       mode_fault,
  output logic       dest_protected,
  output logic       busy
);

  seq_state_e state, state_nxt;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [3:0]         dest_sel;
  logic               data_write;
  logic               illegal;

  logic [5:0] ack_nxt;
  logic       enable_nxt;
  logic [2:0] control_nxt;
  logic [3:0] dest_nxt;
  logic       priv_nxt;
  logic       fault_nxt;
  logic       prot_nxt;
  logic       busy_nxt;

  assign req = {req_trap, req_rett, req_mem, req_alu, req_cpxr, req_pc};

  regbank_prio_arbiter u_arbiter (
    .req   (req),
    .grant (grant)
  );

  // Only the data-carrying requesters name a destination; the rest write index 0.
  always_comb begin
    dest_sel = 4'd0;
    if (grant[REQ_MEM])       dest_sel = dest_mem;
    else if (grant[REQ_ALU])  dest_sel = dest_alu;
    else if (grant[REQ_CPXR]) dest_sel = dest_cpxr;
  end

  assign data_write = grant[REQ_MEM] | grant[REQ_ALU] | grant[REQ_CPXR];
  assign illegal    = (grant[REQ_TRAP] & privileged) | (grant[REQ_RETT] & ~privileged);

  always_ff @(posedge fast_clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ack_nxt     = '0;
    enable_nxt  = 1'b0;
    control_nxt = CTRL_PCSP;
    dest_nxt    = 4'd0;
    priv_nxt    = privileged;
    fault_nxt   = 1'b0;
    prot_nxt    = 1'b0;
    busy_nxt    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt = ST_ISSUE;
          busy_nxt  = 1'b1;
          ack_nxt   = grant;
          dest_nxt  = dest_sel;
          if (illegal) begin
            fault_nxt = 1'b1;
          end else begin
            enable_nxt  = 1'b1;
            control_nxt = ctrl_code(grant);
          end
          prot_nxt = data_write &&
                     ((dest_sel == PC_REGISTER) || (dest_sel == SP_REGISTER));
        end
      end
      ST_ISSUE: begin
        // The registered ack still holds the latched winner here.
        state_nxt = ST_SETTLE;
        busy_nxt  = 1'b1;
        if (ack[REQ_TRAP] && !mode_fault) priv_nxt = 1'b1;
        if (ack[REQ_RETT] && !mode_fault) priv_nxt = 1'b0;
      end
      ST_SETTLE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge fast_clock or negedge reset) begin
    if (!reset) begin
      ack            <= '0;
      bank_enable    <= 1'b0;
      bank_control   <= CTRL_PCSP;
      bank_dest      <= 4'd0;
      privileged     <= 1'b0;
      mode_fault     <= 1'b0;
      dest_protected <= 1'b0;
      busy           <= 1'b0;
    end else begin
      ack            <= ack_nxt;
      bank_enable    <= enable_nxt;
      bank_control   <= control_nxt;
      bank_dest      <= dest_nxt;
      privileged     <= priv_nxt;
      mode_fault     <= fault_nxt;
      dest_protected <= prot_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule

// File: doc/regbank_sequencer.md
# regbank_sequencer

Single-clock controller that sequences all writes into the CPU register bank. It arbitrates among six write requesters: trap entry, trap return, memory load, ALU writeback, special-register copy and plain PC/SP advance. It issues exactly one bank operation per grant as a one-cycle `enable` strobe with the matching 3-bit control code and destination, then inserts a settle cycle so the bank's registered read ports refresh. It also tracks privileged (kernel) mode and rejects illegal trap/return requests.

## Interface
Parameters:
- `PC_REGISTER`, 15, bank index of PC; used for protected-destination detection.
- `SP_REGISTER`, 14, bank index of SP; used for protected-destination detection.

Ports:
- `fast_clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; everything clears immediately on assertion.
- `req_trap`, `req_rett`, `req_mem`, `req_alu`, `req_cpxr`, `req_pc`  in  1 each  level requests; held until the matching ack.
- `dest_mem`, `dest_alu`, `dest_cpxr`  in  4 each  destination register of the corresponding requester.
- `ack`  out  6  one-hot grant pulse. Bit order: [5] trap, [4] rett, [3] mem, [2] alu, [1] cpxr, [0] pc.
- `bank_enable`  out  1  one-cycle write strobe to the bank.
- `bank_control`  out  3  bank opcode.
- `bank_dest`  out  4  destination index.
- `privileged`  out  1  1 while in kernel mode.
- `mode_fault`  out  1  one-cycle pulse on an illegal trap or return.
- `dest_protected`  out  1  one-cycle pulse when the issued destination is PC or SP.
- `busy`  out  1  high in ISSUE and SETTLE.

## Operation
- FSM states: IDLE, ISSUE, SETTLE.
  - IDLE goes to ISSUE when any request is high.
  - ISSUE always goes to SETTLE.
  - SETTLE always goes to IDLE.
- Arbitration happens in IDLE. Priority is fixed: trap > rett > mem > alu > cpxr > pc. The winner is latched for the whole operation.
- ISSUE cycle outputs, by winner:
  - mem: `bank_enable`=1, `bank_control`=3, `bank_dest`=`dest_mem`.
  - alu: control 1, dest `dest_alu`.
  - cpxr: control 6, dest `dest_cpxr`.
  - pc: control 0, dest 0.
  - trap (legal): control 4, dest 0; `privileged` set to 1 at the end of ISSUE.
  - rett (legal): control 5, dest 0; `privileged` cleared at the end of ISSUE.
- `ack` bit of the winner pulses during ISSUE. The requester may drop its request in the following cycle.
- Illegal mode requests:
  - trap while `privileged`=1, or rett while `privileged`=0, is illegal.
  - The FSM still passes through ISSUE and pulses `ack` and `mode_fault`.
  - `bank_enable` stays 0 and `privileged` is unchanged.
- If a mem, alu or cpxr destination equals `PC_REGISTER` or `SP_REGISTER`:
  - The operation is issued normally; the bank discards the data write.
  - `dest_protected` pulses in ISSUE.
- SETTLE: all strobes are 0. Pending requests are ignored until the FSM returns to IDLE.
- Requests arriving or dropping during ISSUE/SETTLE do not change the latched winner.

## Timing
- Reset values: state IDLE; `ack`=0, `bank_enable`=0, `bank_control`=0, `bank_dest`=0, `privileged`=0, `mode_fault`=0, `dest_protected`=0, `busy`=0.
- All outputs are registered.
- Latency: a request sampled high in IDLE at edge N gives ISSUE outputs valid from N+1 to N+2. SETTLE follows, and the next grant's ISSUE begins at N+3 at the earliest.
- Throughput: one bank operation per 3 cycles under continuous requests.
- Simultaneous requests: only the highest priority wins. Losers keep their request asserted and are served in later rounds.
- Starvation: lower priorities can starve under continuous higher-priority traffic. This is accepted and documented for the integrating engineer.
- Reset asserted mid-ISSUE: `bank_enable` drops asynchronously and `privileged` returns to 0. The bank's own reset restores the user stack pointer.

## Structure
- Shared package `regbank_pkg`:
  - Control-code constants: `CTRL_PCSP`=0, `CTRL_ALU`=1, `CTRL_MEM`=3, `CTRL_TRAP`=4, `CTRL_RETT`=5, `CTRL_CPXR`=6.
  - Requester index constants.
  - FSM state encoding.
- One sub-module: `regbank_prio_arbiter`. It is a purely combinational 6-input fixed-priority encoder producing a one-hot grant.

## Test plan
- Reset release with `req_alu`=1, `dest_alu`=3 → at cycle 1 `ack`=000100, `bank_enable`=1, control 1, dest 3; cycle 2 SETTLE; `busy` low at cycle 3.
- `req_trap`, `req_mem`, `req_pc` raised in the same cycle → grant order trap, mem, pc at ISSUE cycles 1, 4, 7; `privileged`=1 after the first ISSUE.
- In kernel mode, `req_trap`=1 → `ack`[5] and `mode_fault` pulse, `bank_enable`=0, `privileged` stays 1. Then `req_rett` → control 5 issued and `privileged`=0.
- In user mode, `req_rett`=1 → `mode_fault` pulse, no enable.
- `req_mem` with `dest_mem`=15 → control 3, dest 15, `dest_protected` pulse.
- `reset` pulled low during ISSUE of a trap → all outputs 0 immediately, `privileged`=0. After release, a held `req_alu` is served 1 cycle later.
